// File: rtl/llki_key_sequencer.sv
// llki_key_sequencer
// Takes one SRoT command at a time and sequences an LLKI key load or a key
// clear into one of NUM_TSS Mock TSS instances. A LOAD reads key words from a
// synchronous key RAM and pushes them, word 0 first, to the selected TSS over
// the valid/ready discrete interface. A CLEAR holds the clear request until
// that TSS acknowledges it. Every TSS handshake is bounded by a timeout.
module llki_key_sequencer #(
  parameter int NUM_TSS        = 4,
  parameter int TGT_W          = 2,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [TGT_W-1:0]   cmd_target,
  input  logic [ADDR_W-1:0]  cmd_base_addr,
  input  logic [7:0]         cmd_num_words,
  output logic               key_rd_en,
  output logic [ADDR_W-1:0]  key_rd_addr,
  input  logic [63:0]        key_rd_data,
  output logic [63:0]        llkid_key_data,
  output logic [NUM_TSS-1:0] llkid_key_valid,
  input  logic [NUM_TSS-1:0] llkid_key_ready,
  output logic [NUM_TSS-1:0] llkid_clear_key,
  input  logic [NUM_TSS-1:0] llkid_clear_key_ack,
  output logic               rsp_valid,
  output logic [1:0]         rsp_status
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_BAD_CMD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_CLEAR    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_r;
  logic [NUM_TSS-1:0]  tgt_onehot_r;   // selected target, latched at accept
  logic [ADDR_W-1:0]   base_r;
  logic [7:0]          num_words_r;
  logic [7:0]          word_idx_r;     // words already transferred
  logic [TO_W-1:0]     timer_r;        // cycles spent in the current handshake state
  logic                fetch_data_r;   // second FETCH cycle: RAM data is valid
  logic                wait_armed_r;   // ready may be trusted from now on

  logic                tgt_ready_s;
  logic                tgt_ack_s;
  logic                timer_exp_s;
  logic                cmd_bad_s;
  logic [NUM_TSS-1:0]  cmd_onehot_s;

  // Selected-target handshake inputs, timeout detect and command decode
  always_comb begin
    tgt_ready_s  = |(llkid_key_ready & tgt_onehot_r);
    tgt_ack_s    = |(llkid_clear_key_ack & tgt_onehot_r);
    timer_exp_s  = (timer_r == TO_W'(TIMEOUT_CYCLES - 1));
    cmd_onehot_s = NUM_TSS'(1'b1) << cmd_target;
    cmd_bad_s    = (32'(cmd_target) >= 32'(NUM_TSS)) ||
                   ((cmd_op == 1'b0) && (cmd_num_words == 8'd0));
  end

  // Command sequencer: state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cmd_ready       <= 1'b1;
      key_rd_en       <= 1'b0;
      key_rd_addr     <= '0;
      llkid_key_data  <= 64'd0;
      llkid_key_valid <= '0;
      llkid_clear_key <= '0;
      rsp_valid       <= 1'b0;
      rsp_status      <= STATUS_OK;
      tgt_onehot_r    <= '0;
      base_r          <= '0;
      num_words_r     <= 8'd0;
      word_idx_r      <= 8'd0;
      timer_r         <= '0;
      fetch_data_r    <= 1'b0;
      wait_armed_r    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them
      key_rd_en <= 1'b0;
      rsp_valid <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready    <= 1'b0;
            tgt_onehot_r <= cmd_onehot_s;
            base_r       <= cmd_base_addr;
            num_words_r  <= cmd_num_words;
            word_idx_r   <= 8'd0;
            timer_r      <= '0;
            fetch_data_r <= 1'b0;
            wait_armed_r <= 1'b0;
            if (cmd_bad_s) begin
              rsp_valid  <= 1'b1;
              rsp_status <= STATUS_BAD_CMD;
              state_r    <= S_DONE;
            end else if (cmd_op) begin
              llkid_clear_key <= cmd_onehot_s;
              state_r         <= S_CLEAR;
            end else begin
              key_rd_en   <= 1'b1;
              key_rd_addr <= cmd_base_addr;
              state_r     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (fetch_data_r) begin
            fetch_data_r    <= 1'b0;
            llkid_key_data  <= key_rd_data;
            llkid_key_valid <= tgt_onehot_r;
            timer_r         <= '0;
            state_r         <= S_SEND;
          end else begin
            fetch_data_r <= 1'b1;
          end
        end

        S_SEND: begin
          if (tgt_ready_s) begin
            llkid_key_valid <= '0;
            word_idx_r      <= word_idx_r + 8'd1;
            timer_r         <= '0;
            wait_armed_r    <= 1'b0;
            state_r         <= S_WAIT_RDY;
          end else if (timer_exp_s) begin
            llkid_key_valid <= '0;
            rsp_valid       <= 1'b1;
            rsp_status      <= STATUS_TIMEOUT;
            state_r         <= S_DONE;
          end else begin
            timer_r <= timer_r + TO_W'(1);
          end
        end

        // The TSS registers ready, so the cycle right after a transfer still
        // shows the stale value; only the armed cycles are sampled.
        S_WAIT_RDY: begin
          if (wait_armed_r && tgt_ready_s) begin
            wait_armed_r <= 1'b0;
            if (word_idx_r == num_words_r) begin
              rsp_valid  <= 1'b1;
              rsp_status <= STATUS_OK;
              state_r    <= S_DONE;
            end else begin
              key_rd_en   <= 1'b1;
              key_rd_addr <= base_r + ADDR_W'(word_idx_r);
              state_r     <= S_FETCH;
            end
          end else if (timer_exp_s) begin
            rsp_valid  <= 1'b1;
            rsp_status <= STATUS_TIMEOUT;
            state_r    <= S_DONE;
          end else begin
            wait_armed_r <= 1'b1;
            timer_r      <= timer_r + TO_W'(1);
          end
        end

        S_CLEAR: begin
          if (tgt_ack_s) begin
            llkid_clear_key <= '0;
            rsp_valid       <= 1'b1;
            rsp_status      <= STATUS_OK;
            state_r         <= S_DONE;
          end else if (timer_exp_s) begin
            llkid_clear_key <= '0;
            rsp_valid       <= 1'b1;
            rsp_status      <= STATUS_TIMEOUT;
            state_r         <= S_DONE;
          end else begin
            timer_r <= timer_r + TO_W'(1);
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          state_r   <= S_IDLE;
        end

        default: begin
          llkid_key_valid <= '0;
          llkid_clear_key <= '0;
          cmd_ready       <= 1'b1;
          state_r         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llki_key_sequencer.sv
// Directed and randomized bench for llki_key_sequencer with a key RAM model,
// behavioural TSS models (programmable wait states, ack enables) and an
// expected-result model built from the command fields.
module tb_llki_key_sequencer;

  localparam int NT = 4;
  localparam int TW = 3;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [TW-1:0] cmd_target;
  logic [AW-1:0] cmd_base_addr;
  logic [7:0]    cmd_num_words;
  logic          key_rd_en;
  logic [AW-1:0] key_rd_addr;
  logic [63:0]   key_rd_data;
  logic [63:0]   llkid_key_data;
  logic [NT-1:0] llkid_key_valid;
  logic [NT-1:0] llkid_key_ready;
  logic [NT-1:0] llkid_clear_key;
  logic [NT-1:0] llkid_clear_key_ack;
  logic          rsp_valid;
  logic [1:0]    rsp_status;

  always #5 clk = ~clk;

  llki_key_sequencer #(
    .NUM_TSS(NT), .TGT_W(TW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_target(cmd_target), .cmd_base_addr(cmd_base_addr),
    .cmd_num_words(cmd_num_words),
    .key_rd_en(key_rd_en), .key_rd_addr(key_rd_addr), .key_rd_data(key_rd_data),
    .llkid_key_data(llkid_key_data), .llkid_key_valid(llkid_key_valid),
    .llkid_key_ready(llkid_key_ready), .llkid_clear_key(llkid_clear_key),
    .llkid_clear_key_ack(llkid_clear_key_ack),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status)
  );

  // ---------------- key RAM model ----------------
  logic [63:0] ram [256];
  logic [7:0]  rd_log [$];

  always @(posedge clk) begin
    if (key_rd_en) begin
      key_rd_data <= ram[key_rd_addr];
      rd_log.push_back(key_rd_addr);
    end
  end

  // ---------------- TSS models ----------------
  int            tss_wait [NT];
  logic [NT-1:0] tie_low;
  logic [NT-1:0] ack_en;
  int            busy [NT];
  logic [66:0]   rx_log [$];

  always_comb begin
    for (int i = 0; i < NT; i++) llkid_key_ready[i] = (busy[i] == 0) && !tie_low[i];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) busy[i] <= 0;
      llkid_clear_key_ack <= '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (llkid_key_valid[i] && llkid_key_ready[i]) begin
          rx_log.push_back({3'(i), llkid_key_data});
          busy[i] <= tss_wait[i];
        end else if (busy[i] > 0) begin
          busy[i] <= busy[i] - 1;
        end
      end
      llkid_clear_key_ack <= llkid_clear_key & ack_en;
    end
  end

  // ---------------- monitor ----------------
  int            cyc = 0;
  int            rsp_cnt = 0;
  int            rsp_cyc = 0;
  int            foreign_cnt = 0;
  int            valid_hi_cnt = 0;
  int            clear_hi_cnt = 0;
  logic [1:0]    last_status = 2'b11;
  logic [NT-1:0] sel_mask = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc     = cyc;
        last_status = rsp_status;
      end
      if (((llkid_key_valid | llkid_clear_key) & ~sel_mask) != '0) foreign_cnt++;
      if (llkid_key_valid != '0) valid_hi_cnt++;
      if (llkid_clear_key != '0) clear_hi_cnt++;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int         acc_cyc, lat, rsp0, rx0, rd0, f0, v0, c0;
  logic [1:0] status_q;

  task automatic snapshot(input logic [TW-1:0] tgt);
    sel_mask = (32'(tgt) < NT) ? (NT'(1) << tgt) : '0;
    rsp0 = rsp_cnt;
    rx0  = rx_log.size();
    rd0  = rd_log.size();
    f0   = foreign_cnt;
    v0   = valid_hi_cnt;
    c0   = clear_hi_cnt;
  endtask

  // Issue one command and wait (bounded) for its response
  task automatic run_cmd(input logic op, input logic [TW-1:0] tgt,
                         input logic [7:0] base, input logic [7:0] nw);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    snapshot(tgt);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt;
    cmd_base_addr = base; cmd_num_words = nw;
    tick();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(cmd_ready), 64'd0);
    n = 0;
    while (rsp_cnt == rsp0 && n < 200) begin tick(); n++; end
    check("rsp_arrived", 64'(rsp_cnt != rsp0), 64'd1);
    lat      = rsp_cyc - acc_cyc;
    status_q = last_status;
    repeat (3) tick();
    check("rsp_one_cycle", 64'(rsp_cnt - rsp0), 64'd1);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("valid_idle", 64'(llkid_key_valid), 64'd0);
    check("clear_idle", 64'(llkid_clear_key), 64'd0);
  endtask

  // Compare a completed LOAD against the expected word stream
  task automatic check_load(input logic [TW-1:0] tgt, input logic [7:0] base,
                            input logic [7:0] nw);
    logic [7:0] a;
    check("load_status", 64'(status_q), 64'(2'b00));
    check("load_nreads", 64'(rd_log.size() - rd0), 64'(nw));
    check("load_nwords", 64'(rx_log.size() - rx0), 64'(nw));
    if (rd_log.size() - rd0 == int'(nw) && rx_log.size() - rx0 == int'(nw)) begin
      for (int i = 0; i < int'(nw); i++) begin
        a = base + 8'(i);
        check("load_rd_addr", 64'(rd_log[rd0 + i]), 64'(a));
        check("load_rx_tgt", 64'(rx_log[rx0 + i][66:64]), 64'(tgt));
        check("load_rx_data", rx_log[rx0 + i][63:0], ram[a]);
      end
    end
    check("load_no_foreign", 64'(foreign_cnt - f0), 64'd0);
    check("load_lat_min", 64'(lat >= 4 * int'(nw) + 1), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [TW-1:0] rt;
    logic [7:0]    rb, rn;
    int            n;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_target = '0;
    cmd_base_addr = '0; cmd_num_words = 8'd0;
    tie_low = '0; ack_en = '1;
    for (int i = 0; i < NT; i++) tss_wait[i] = 0;
    for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom};
    ram[8'h10] = 64'hAAAA_0000_1111_2222;
    ram[8'h11] = 64'hBBBB_3333_4444_5555;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rd_en", 64'(key_rd_en), 64'd0);
    check("rst_rd_addr", 64'(key_rd_addr), 64'd0);
    check("rst_key_data", llkid_key_data, 64'd0);
    check("rst_valid", 64'(llkid_key_valid), 64'd0);
    check("rst_clear", 64'(llkid_clear_key), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: two-word LOAD into target 0 with 4 TSS wait states
    tss_wait[0] = 4;
    run_cmd(1'b0, 3'd0, 8'h10, 8'd2);
    check_load(3'd0, 8'h10, 8'd2);

    // 2: CLEAR target 2, idle TSS acks promptly
    run_cmd(1'b1, 3'd2, 8'h00, 8'd0);
    check("clr_status", 64'(status_q), 64'(2'b00));
    check("clr_lat_le4", 64'(lat <= 4), 64'd1);
    check("clr_seen", 64'(clear_hi_cnt - c0 >= 1), 64'd1);
    check("clr_no_valid", 64'(valid_hi_cnt - v0), 64'd0);
    check("clr_no_read", 64'(rd_log.size() - rd0), 64'd0);
    check("clr_no_foreign", 64'(foreign_cnt - f0), 64'd0);

    // 3: LOAD into target 1 whose ready is stuck low
    tie_low = 4'b0010;
    run_cmd(1'b0, 3'd1, 8'h40, 8'd2);
    check("to_status", 64'(status_q), 64'(2'b01));
    check("to_valid_cycles", 64'(valid_hi_cnt - v0), 64'(TO));
    check("to_no_rx", 64'(rx_log.size() - rx0), 64'd0);
    check("to_one_read", 64'(rd_log.size() - rd0), 64'd1);
    check("to_no_foreign", 64'(foreign_cnt - f0), 64'd0);
    tie_low = '0;

    // CLEAR whose ack never comes
    ack_en = 4'b1110;
    run_cmd(1'b1, 3'd0, 8'h00, 8'd0);
    check("clr_to_status", 64'(status_q), 64'(2'b01));
    check("clr_to_cycles", 64'(clear_hi_cnt - c0), 64'(TO));
    ack_en = '1;

    // 4: bad commands
    run_cmd(1'b0, 3'd5, 8'h20, 8'd2);
    check("bad_tgt_status", 64'(status_q), 64'(2'b10));
    check("bad_tgt_no_read", 64'(rd_log.size() - rd0), 64'd0);
    check("bad_tgt_no_valid", 64'(valid_hi_cnt - v0), 64'd0);
    run_cmd(1'b1, 3'd4, 8'h00, 8'd0);
    check("bad_clr_status", 64'(status_q), 64'(2'b10));
    check("bad_clr_no_clear", 64'(clear_hi_cnt - c0), 64'd0);
    run_cmd(1'b0, 3'd1, 8'h30, 8'd0);
    check("bad_nw0_status", 64'(status_q), 64'(2'b10));
    check("bad_nw0_no_read", 64'(rd_log.size() - rd0), 64'd0);
    check("bad_nw0_no_valid", 64'(valid_hi_cnt - v0), 64'd0);

    // 5: address wrap
    tss_wait[3] = 1;
    run_cmd(1'b0, 3'd3, 8'hFF, 8'd3);
    check_load(3'd3, 8'hFF, 8'd3);

    // Randomized LOADs against the expected word stream
    for (int k = 0; k < 6; k++) begin
      rt = 3'($urandom_range(0, NT - 1));
      rb = 8'($urandom_range(0, 255));
      rn = 8'($urandom_range(1, 5));
      tss_wait[rt] = $urandom_range(0, 5);
      run_cmd(1'b0, rt, rb, rn);
      check_load(rt, rb, rn);
    end

    // 6: reset during SEND of word 1
    tss_wait[3] = 2;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    snapshot(3'd3);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_target = 3'd3;
    cmd_base_addr = 8'h80; cmd_num_words = 8'd3;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(llkid_key_valid[3] && rx_log.size() - rx0 == 1) && n < 100) begin tick(); n++; end
    check("rst_mid_reached_send1", 64'(llkid_key_valid[3] && rx_log.size() - rx0 == 1), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 64'(llkid_key_valid), 64'd0);
    check("rst_mid_clear", 64'(llkid_clear_key), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    rsp0 = rsp_cnt;
    repeat (10) tick();
    check("rst_mid_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    check("rst_mid_idle_ready", 64'(cmd_ready), 64'd1);

    // Operation after the abort
    run_cmd(1'b0, 3'd2, 8'h05, 8'd2);
    check_load(3'd2, 8'h05, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
